// File: rtl/spi_frame_receiver_if.sv
// -----------------------------------------------------------------------------
// spi_frame_receiver_if
// This interface bundles the serial-side and consumer-side signals of
// spi_frame_receiver. The clock (SLK) and the reset (rst) stay plain ports.
//   CS         master->slave  frame enable, active-high
//   MOSI       master->slave  serial data, MSB first
//   data_ack   master->slave  consumer accepts data_out
//   data_out   slave->master  last accepted 16-bit word
//   data_valid slave->master  data_out holds an unconsumed word
//   overrun    slave->master  sticky: a completed word was dropped
//   frame_err  slave->master  one-cycle pulse on abort (or parity fail)
//   busy       slave->master  a frame is partially received
// -----------------------------------------------------------------------------
interface spi_frame_receiver_if;
  logic        CS;
  logic        MOSI;
  logic        data_ack;
  logic [15:0] data_out;
  logic        data_valid;
  logic        overrun;
  logic        frame_err;
  logic        busy;

  modport master (
    output CS, MOSI, data_ack,
    input  data_out, data_valid, overrun, frame_err, busy
  );

  modport slave (
    input  CS, MOSI, data_ack,
    output data_out, data_valid, overrun, frame_err, busy
  );
endinterface

// File: rtl/spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// spi_frame_receiver
// Serial frame receiver. While CS is high, one MOSI bit is sampled on every
// rising SLK edge, MSB first. A completed 16-bit word is handed to the
// consumer through a single-entry holding register (data_out/data_valid)
// with a data_ack handshake. A word that completes while the holding
// register is still full is dropped and flagged by the sticky overrun.
// Ports:
//   SLK   - the single clock, rising edge
//   rst   - asynchronous reset, active-low
//   bus   - spi_frame_receiver_if.slave (CS, MOSI, data_ack in;
//           data_out, data_valid, overrun, frame_err, busy out)
// Optional feature macro: RX_PARITY_EN
//   Defined: frames are 17 bits long, the last bit being an even-parity bit
//   over the 16 data bits; a parity failure discards the word and pulses
//   frame_err. Undefined: frames are 16 bits long, no parity logic.
// -----------------------------------------------------------------------------
module spi_frame_receiver (
  input  logic                 SLK,
  input  logic                 rst,
  spi_frame_receiver_if.slave  bus
);

`ifdef RX_PARITY_EN
  localparam int unsigned N    = 17;
  // All 16 data bits are held in the register; the parity bit arrives on MOSI.
  localparam int unsigned SR_W = 16;

  // Even parity: data plus parity bit must contain an even number of ones.
  function automatic logic parity_ok(input logic [15:0] data, input logic par);
    parity_ok = ~(^{data, par});
  endfunction
`else
  localparam int unsigned N    = 16;
  // The 16th bit is taken straight from MOSI on the completing edge, so only
  // the first 15 bits need to be stored.
  localparam int unsigned SR_W = 15;
`endif

  localparam logic [4:0] LAST_CNT = 5'(N - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [4:0]      r_cnt;
  logic [4:0]      w_cnt_nxt;
  logic [SR_W-1:0] r_shift;
  logic [SR_W-1:0] w_shift_nxt;

  logic [15:0]     r_data_out;
  logic            r_data_valid;
  logic            r_overrun;
  logic            r_frame_err;
  logic            r_busy;
  logic [15:0]     w_data_out_nxt;
  logic            w_data_valid_nxt;
  logic            w_overrun_nxt;
  logic            w_frame_err_nxt;
  logic            w_busy_nxt;

  logic            w_last;
  logic            w_abort;
  logic            w_good;
  logic [15:0]     w_word;

  assign w_last  = bus.CS && (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);
  assign w_abort = !bus.CS && (r_state == ST_SHIFT) && (r_cnt != 5'd0);

`ifdef RX_PARITY_EN
  assign w_word = r_shift;
  assign w_good = w_last && parity_ok(r_shift, bus.MOSI);
`else
  assign w_word = {r_shift, bus.MOSI};
  assign w_good = w_last;
`endif

  // State register plus datapath and registered outputs.
  always_ff @(posedge SLK or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 5'd0;
      r_shift      <= '0;
      r_data_out   <= 16'h0000;
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_data_out   <= w_data_out_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_overrun    <= w_overrun_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Next-state logic: frame sequencing, bit counter and shift register.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    case (r_state)
      ST_IDLE: begin
        if (bus.CS) begin
          // The first bit is sampled on the same edge that leaves IDLE.
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = 5'd1;
          w_shift_nxt = {r_shift[SR_W-2:0], bus.MOSI};
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 5'd0;
          w_shift_nxt = r_shift;
        end
      end
      ST_SHIFT: begin
        if (bus.CS) begin
          // Stay in SHIFT across a completion so back-to-back frames need no gap.
          w_state_nxt = ST_SHIFT;
          if (w_last) begin
            w_cnt_nxt   = 5'd0;
            w_shift_nxt = '0;
          end else begin
            w_cnt_nxt   = r_cnt + 5'd1;
            w_shift_nxt = {r_shift[SR_W-2:0], bus.MOSI};
          end
        end else begin
          // Either a clean gap (count 0) or an abort; the partial word is dropped.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 5'd0;
          w_shift_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 5'd0;
        w_shift_nxt = '0;
      end
    endcase
  end

  // Output logic: holding register, overrun, error pulse and busy.
  always_comb begin
    w_data_out_nxt   = r_data_out;
    w_data_valid_nxt = r_data_valid;
    w_overrun_nxt    = r_overrun;
    w_frame_err_nxt  = w_abort || (w_last && !w_good);
    w_busy_nxt       = (w_cnt_nxt != 5'd0);
    if (w_good) begin
      if (!r_data_valid || bus.data_ack) begin
        // Accepted; an ack on the same edge consumes the previous word and
        // therefore also clears a pending overrun.
        w_data_out_nxt   = w_word;
        w_data_valid_nxt = 1'b1;
        if (r_data_valid) begin
          w_overrun_nxt = 1'b0;
        end else begin
          w_overrun_nxt = r_overrun;
        end
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end else begin
      if (r_data_valid && bus.data_ack) begin
        w_data_valid_nxt = 1'b0;
        w_overrun_nxt    = 1'b0;
      end else begin
        w_data_valid_nxt = r_data_valid;
        w_overrun_nxt    = r_overrun;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.overrun    = r_overrun;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_receiver
// Directed scenarios followed by random traffic. A queue-based reference
// model collects received bits per frame and applies the handshake rules.
// -----------------------------------------------------------------------------
module tb_spi_frame_receiver;

`ifdef RX_PARITY_EN
  localparam int N = 17;
`else
  localparam int N = 16;
`endif

  logic SLK;
  logic rst;
  spi_frame_receiver_if bus ();

  spi_frame_receiver dut (
    .SLK (SLK),
    .rst (rst),
    .bus (bus.slave)
  );

  initial SLK = 1'b0;
  always #5 SLK = ~SLK;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  logic        q_bits[$];
  logic [15:0] m_dout;
  logic        m_valid;
  logic        m_ovr;
  logic        m_err;
  logic        m_busy;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".data_out"},   bus.data_out,          m_dout);
    chk({tag, ".data_valid"}, {15'd0, bus.data_valid}, {15'd0, m_valid});
    chk({tag, ".overrun"},    {15'd0, bus.overrun},    {15'd0, m_ovr});
    chk({tag, ".frame_err"},  {15'd0, bus.frame_err},  {15'd0, m_err});
    chk({tag, ".busy"},       {15'd0, bus.busy},       {15'd0, m_busy});
  endtask

  task automatic model_reset();
    q_bits.delete();
    m_dout  = 16'h0000;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_err   = 1'b0;
    m_busy  = 1'b0;
  endtask

  task automatic model_edge(input logic cs, input logic mosi, input logic ack);
    logic        done;
    logic        ok;
    logic [15:0] word;
    int          ones;
    done  = 1'b0;
    ok    = 1'b0;
    word  = 16'h0000;
    m_err = 1'b0;
    if (cs) begin
      q_bits.push_back(mosi);
      if (q_bits.size() == N) begin
        done = 1'b1;
        ones = 0;
        for (int i = 0; i < 16; i++) word = {word[14:0], q_bits[i]};
        for (int i = 0; i < N; i++) ones += int'(q_bits[i]);
        ok = (N == 16) || (ones % 2 == 0);
        q_bits.delete();
      end
    end else if (q_bits.size() != 0) begin
      m_err = 1'b1;
      q_bits.delete();
    end
    if (done && !ok) m_err = 1'b1;
    if (done && ok) begin
      if (!m_valid || ack) begin
        if (m_valid) m_ovr = 1'b0;
        m_dout  = word;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && ack) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    m_busy = (q_bits.size() != 0);
  endtask

  task automatic step(input logic cs, input logic mosi, input logic ack);
    bus.CS       = cs;
    bus.MOSI     = mosi;
    bus.data_ack = ack;
    @(posedge SLK);
    model_edge(cs, mosi, ack);
    #1;
    chk_model("step");
  endtask

  task automatic send_frame(input logic [15:0] w, input logic ack_last, input logic bad_par);
    logic b;
    for (int i = 0; i < N; i++) begin
      if (i < 16) b = w[15-i];
      else        b = (^w) ^ bad_par;
      step(1'b1, b, (i == N-1) ? ack_last : 1'b0);
    end
  endtask

  initial begin
    rst          = 1'b0;
    bus.CS       = 1'b0;
    bus.MOSI     = 1'b0;
    bus.data_ack = 1'b0;
    model_reset();
    #12;
    chk_model("reset");
    rst = 1'b1;

    // Basic reception
    send_frame(16'hA5C3, 1'b0, 1'b0);
    chk("a5c3.dout", bus.data_out, 16'hA5C3);
    chk("a5c3.valid", {15'd0, bus.data_valid}, 16'd1);
    chk("a5c3.busy", {15'd0, bus.busy}, 16'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("a5c3.acked", {15'd0, bus.data_valid}, 16'd0);

    // Back-to-back frames, ack on the completing edge of the second
    send_frame(16'h1234, 1'b0, 1'b0);
    send_frame(16'hBEEF, 1'b1, 1'b0);
    chk("b2b.dout", bus.data_out, 16'hBEEF);
    chk("b2b.valid", {15'd0, bus.data_valid}, 16'd1);
    chk("b2b.ovr", {15'd0, bus.overrun}, 16'd0);
    step(1'b0, 1'b0, 1'b1);

    // Overrun
    send_frame(16'h00FF, 1'b0, 1'b0);
    send_frame(16'hFFFF, 1'b0, 1'b0);
    chk("ovr.dout", bus.data_out, 16'h00FF);
    chk("ovr.flag", {15'd0, bus.overrun}, 16'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("ovr.clr_valid", {15'd0, bus.data_valid}, 16'd0);
    chk("ovr.clr_flag", {15'd0, bus.overrun}, 16'd0);

    // Abort after 7 bits
    for (int i = 0; i < 7; i++) step(1'b1, i[0], 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("abort.err", {15'd0, bus.frame_err}, 16'd1);
    chk("abort.busy", {15'd0, bus.busy}, 16'd0);
    chk("abort.valid", {15'd0, bus.data_valid}, 16'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("abort.err_pulse", {15'd0, bus.frame_err}, 16'd0);
    send_frame(16'h0F0F, 1'b0, 1'b0);
    chk("abort.next", bus.data_out, 16'h0F0F);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 9; i++) step(1'b1, i[1], 1'b0);
    rst = 1'b0;
    #1;
    model_reset();
    chk_model("async_rst");
    @(posedge SLK);
    #1;
    chk_model("rst_hold");
    rst = 1'b1;
    send_frame(16'h8001, 1'b0, 1'b0);
    chk("rst.next", bus.data_out, 16'h8001);
    step(1'b0, 1'b0, 1'b1);

`ifdef RX_PARITY_EN
    send_frame(16'h0003, 1'b0, 1'b0);
    chk("par.good", bus.data_out, 16'h0003);
    step(1'b0, 1'b0, 1'b1);
    send_frame(16'h0003, 1'b0, 1'b1);
    chk("par.bad_err", {15'd0, bus.frame_err}, 16'd1);
    chk("par.bad_valid", {15'd0, bus.data_valid}, 16'd0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 11) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
